// File: rtl/program_loader.sv
// Boot-time program loader: requests a program over UART (0x99), receives a
// little-endian size and payload, writes 32-bit words to program memory, then acknowledges (0xAA).
module program_loader #(
    parameter int ADDR_WIDTH = 15
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic                  rx_valid,
    input  logic [7:0]            rx_data,
    input  logic                  tx_ready,
    output logic                  tx_valid,
    output logic [7:0]            tx_data,
    output logic                  prog_we,
    output logic [ADDR_WIDTH-1:0] prog_addr,
    output logic [31:0]           prog_wdata,
    output logic [31:0]           program_data_size,
    output logic                  program_data_size_fetch_finished,
    output logic                  program_data_fetch_finished,
    output logic                  overflow,
    output logic                  busy
);

    typedef enum logic [2:0] {
        IDLE,
        SEND_99,
        RECV_SIZE,
        RECV_DATA,
        FLUSH,
        SEND_AA,
        DONE
    } state_t;

    state_t      state;
    logic [31:0] byte_count;
    logic [31:0] word_buf;
    logic [31:0] merged_word;
    logic [1:0]  lane;
    logic        last_byte;
    logic        word_full;
    logic        beyond_capacity;

    // Both the size field and payload words are assembled little-endian,
    // so the lane is simply the low two bits of the running byte count.
    assign lane            = byte_count[1:0];
    assign word_full       = (lane == 2'd3);
    assign last_byte       = (byte_count == program_data_size - 32'd1);
    assign beyond_capacity = ((byte_count >> (ADDR_WIDTH + 2)) != 32'd0);

    always_comb begin
        merged_word = word_buf;
        case (lane)
            2'd0:    merged_word[7:0]   = rx_data;
            2'd1:    merged_word[15:8]  = rx_data;
            2'd2:    merged_word[23:16] = rx_data;
            default: merged_word[31:24] = rx_data;
        endcase
    end

    assign tx_valid = (state == SEND_99) || (state == SEND_AA);
    assign tx_data  = (state == SEND_99) ? 8'h99 :
                      (state == SEND_AA) ? 8'hAA : 8'h00;
    assign busy     = !((state == IDLE) || (state == DONE));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state                            <= IDLE;
            byte_count                       <= 32'd0;
            word_buf                         <= 32'd0;
            prog_we                          <= 1'b0;
            prog_addr                        <= '0;
            prog_wdata                       <= 32'd0;
            program_data_size                <= 32'd0;
            program_data_size_fetch_finished <= 1'b0;
            program_data_fetch_finished      <= 1'b0;
            overflow                         <= 1'b0;
        end else begin
            prog_we <= 1'b0;
            // The address advances once the write it belongs to has been issued.
            if (prog_we) begin
                prog_addr <= prog_addr + ADDR_WIDTH'(1);
            end
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state                            <= SEND_99;
                        byte_count                       <= 32'd0;
                        word_buf                         <= 32'd0;
                        prog_addr                        <= '0;
                        program_data_size                <= 32'd0;
                        program_data_size_fetch_finished <= 1'b0;
                        program_data_fetch_finished      <= 1'b0;
                        overflow                         <= 1'b0;
                    end
                end
                SEND_99: begin
                    if (tx_ready) begin
                        state <= RECV_SIZE;
                    end
                end
                RECV_SIZE: begin
                    if (rx_valid) begin
                        if (word_full) begin
                            program_data_size                <= merged_word;
                            program_data_size_fetch_finished <= 1'b1;
                            byte_count                       <= 32'd0;
                            word_buf                         <= 32'd0;
                            state <= (merged_word == 32'd0) ? SEND_AA : RECV_DATA;
                        end else begin
                            word_buf   <= merged_word;
                            byte_count <= byte_count + 32'd1;
                        end
                    end
                end
                RECV_DATA: begin
                    if (rx_valid) begin
                        byte_count <= byte_count + 32'd1;
                        if (beyond_capacity) begin
                            overflow <= 1'b1;
                        end
                        // Words past the end of memory are still consumed, just never written.
                        if (word_full || last_byte) begin
                            word_buf <= 32'd0;
                            if (!beyond_capacity) begin
                                prog_we    <= 1'b1;
                                prog_wdata <= merged_word;
                            end
                        end else begin
                            word_buf <= merged_word;
                        end
                        if (last_byte) begin
                            state <= FLUSH;
                        end
                    end
                end
                FLUSH: begin
                    state <= SEND_AA;
                end
                SEND_AA: begin
                    if (tx_ready) begin
                        program_data_fetch_finished <= 1'b1;
                        state                       <= DONE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// Directed testbench for program_loader: a default-width instance plus a
// 4-word instance sharing the same stimulus for the capacity scenario.
module tb_program_loader;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        tx_ready = 1'b1;

    logic        tx_valid, prog_we, size_done, data_done, overflow, busy;
    logic [7:0]  tx_data;
    logic [14:0] prog_addr;
    logic [31:0] prog_wdata, prog_size;

    logic        s_tx_valid, s_prog_we, s_size_done, s_data_done, s_overflow, s_busy;
    logic [7:0]  s_tx_data;
    logic [1:0]  s_prog_addr;
    logic [31:0] s_prog_wdata, s_prog_size;

    int errors = 0;
    int checks = 0;

    logic [14:0] wr_addr_q[$];
    logic [31:0] wr_data_q[$];
    logic [1:0]  s_wr_addr_q[$];
    logic [31:0] s_wr_data_q[$];
    logic [7:0]  tx_q[$];

    program_loader dut (
        .clk(clk), .reset_n(reset_n), .start(start), .rx_valid(rx_valid),
        .rx_data(rx_data), .tx_ready(tx_ready), .tx_valid(tx_valid),
        .tx_data(tx_data), .prog_we(prog_we), .prog_addr(prog_addr),
        .prog_wdata(prog_wdata), .program_data_size(prog_size),
        .program_data_size_fetch_finished(size_done),
        .program_data_fetch_finished(data_done),
        .overflow(overflow), .busy(busy)
    );

    program_loader #(.ADDR_WIDTH(2)) dut_small (
        .clk(clk), .reset_n(reset_n), .start(start), .rx_valid(rx_valid),
        .rx_data(rx_data), .tx_ready(tx_ready), .tx_valid(s_tx_valid),
        .tx_data(s_tx_data), .prog_we(s_prog_we), .prog_addr(s_prog_addr),
        .prog_wdata(s_prog_wdata), .program_data_size(s_prog_size),
        .program_data_size_fetch_finished(s_size_done),
        .program_data_fetch_finished(s_data_done),
        .overflow(s_overflow), .busy(s_busy)
    );

    always #5 clk = ~clk;

    // Record every memory write and every completed TX handshake mid-cycle.
    always @(negedge clk) begin
        if (prog_we) begin
            wr_addr_q.push_back(prog_addr);
            wr_data_q.push_back(prog_wdata);
        end
        if (s_prog_we) begin
            s_wr_addr_q.push_back(s_prog_addr);
            s_wr_data_q.push_back(s_prog_wdata);
        end
        if (tx_valid && tx_ready) begin
            tx_q.push_back(tx_data);
        end
    end

    task automatic clear_logs();
        wr_addr_q.delete();
        wr_data_q.delete();
        s_wr_addr_q.delete();
        s_wr_data_q.delete();
        tx_q.delete();
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        start = 1'b1;
        next_cycle();
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        next_cycle();
        rx_valid = 1'b0;
    endtask

    task automatic send_size(input logic [31:0] s);
        send_byte(s[7:0]);
        send_byte(s[15:8]);
        send_byte(s[23:16]);
        send_byte(s[31:24]);
    endtask

    task automatic wait_done(input string name);
        for (int i = 0; i < 50; i++) begin
            if (data_done) break;
            next_cycle();
        end
        checks++;
        if (data_done !== 1'b1) begin
            errors++;
            $display("[TB] FAIL %s_done_timeout: got %b required 1", name, data_done);
        end
    endtask

    task automatic test_reset();
        #12;
        checks++;
        if ({tx_valid, tx_data, prog_we, prog_addr, prog_wdata, prog_size,
             size_done, data_done, overflow, busy} !== '0) begin
            errors++;
            $display("[TB] FAIL reset_values: tx_valid=%b tx_data=%h we=%b addr=%h wdata=%h size=%h flags=%b%b ovf=%b busy=%b required all 0",
                     tx_valid, tx_data, prog_we, prog_addr, prog_wdata, prog_size, size_done, data_done, overflow, busy);
        end
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        next_cycle();
    endtask

    task automatic test_basic_load();
        clear_logs();
        do_start();
        checks++;
        if (tx_valid !== 1'b1 || tx_data !== 8'h99 || busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL basic_send99: got valid=%b data=%h busy=%b required 1 99 1", tx_valid, tx_data, busy);
        end
        next_cycle();
        checks++;
        if (tx_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL basic_tx_drop: got %b required 0", tx_valid);
        end
        send_size(32'd8);
        checks++;
        if (size_done !== 1'b1 || prog_size !== 32'd8) begin
            errors++;
            $display("[TB] FAIL basic_size: got flag=%b size=%0d required 1 8", size_done, prog_size);
        end
        send_byte(8'h13); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
        checks++;
        if (prog_we !== 1'b1 || prog_addr !== 15'd0 || prog_wdata !== 32'h00000013) begin
            errors++;
            $display("[TB] FAIL basic_write0: got we=%b addr=%0d data=%h required 1 0 00000013", prog_we, prog_addr, prog_wdata);
        end
        send_byte(8'h93);
        checks++;
        if (prog_we !== 1'b0) begin
            errors++;
            $display("[TB] FAIL basic_we_pulse: got %b required 0", prog_we);
        end
        send_byte(8'h00); send_byte(8'h10); send_byte(8'h00);
        checks++;
        if (prog_we !== 1'b1 || prog_addr !== 15'd1 || prog_wdata !== 32'h00100093) begin
            errors++;
            $display("[TB] FAIL basic_write1: got we=%b addr=%0d data=%h required 1 1 00100093", prog_we, prog_addr, prog_wdata);
        end
        wait_done("basic");
        checks++;
        if (wr_data_q.size() != 2 || tx_q.size() != 2) begin
            errors++;
            $display("[TB] FAIL basic_counts: got writes=%0d tx=%0d required 2 2", wr_data_q.size(), tx_q.size());
        end else if (tx_q[0] !== 8'h99 || tx_q[1] !== 8'hAA) begin
            errors++;
            $display("[TB] FAIL basic_tx_bytes: got %h %h required 99 AA", tx_q[0], tx_q[1]);
        end
        checks++;
        if (size_done !== 1'b1 || busy !== 1'b0 || tx_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL basic_final: got size_flag=%b busy=%b tx_valid=%b required 1 0 0", size_done, busy, tx_valid);
        end
    endtask

    task automatic test_partial_word();
        clear_logs();
        do_start();
        next_cycle();
        send_size(32'd5);
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44); send_byte(8'h55);
        wait_done("partial");
        checks++;
        if (wr_data_q.size() != 2) begin
            errors++;
            $display("[TB] FAIL partial_count: got %0d writes required 2", wr_data_q.size());
        end else if (wr_addr_q[0] !== 15'd0 || wr_data_q[0] !== 32'h44332211 ||
                     wr_addr_q[1] !== 15'd1 || wr_data_q[1] !== 32'h00000055) begin
            errors++;
            $display("[TB] FAIL partial_words: got %0d:%h %0d:%h required 0:44332211 1:00000055",
                     wr_addr_q[0], wr_data_q[0], wr_addr_q[1], wr_data_q[1]);
        end
    endtask

    task automatic test_backpressure();
        clear_logs();
        tx_ready = 1'b0;
        do_start();
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (tx_valid !== 1'b1 || tx_data !== 8'h99) begin
                errors++;
                $display("[TB] FAIL stall_hold_%0d: got valid=%b data=%h required 1 99", i, tx_valid, tx_data);
            end
            send_byte(8'h05);
        end
        tx_ready = 1'b1;
        next_cycle();
        checks++;
        if (tx_valid !== 1'b0 || size_done !== 1'b0) begin
            errors++;
            $display("[TB] FAIL stall_release: got valid=%b size_flag=%b required 0 0", tx_valid, size_done);
        end
        send_size(32'd4);
        checks++;
        if (prog_size !== 32'd4) begin
            errors++;
            $display("[TB] FAIL stall_size: got %0d required 4", prog_size);
        end
        send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC); send_byte(8'hDD);
        wait_done("stall");
        checks++;
        if (wr_data_q.size() != 1 || wr_data_q[0] !== 32'hDDCCBBAA) begin
            errors++;
            $display("[TB] FAIL stall_write: got %0d writes first=%h required 1 DDCCBBAA",
                     wr_data_q.size(), (wr_data_q.size() > 0) ? wr_data_q[0] : 32'h0);
        end
    endtask

    task automatic test_overflow();
        clear_logs();
        do_start();
        next_cycle();
        send_size(32'd20);
        for (int i = 0; i < 20; i++) begin
            send_byte(8'(i + 1));
        end
        wait_done("overflow");
        checks++;
        if (s_wr_data_q.size() != 4) begin
            errors++;
            $display("[TB] FAIL ovf_count: got %0d writes required 4", s_wr_data_q.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                logic [31:0] exp_word;
                exp_word = {8'(4*i + 4), 8'(4*i + 3), 8'(4*i + 2), 8'(4*i + 1)};
                checks++;
                if (s_wr_addr_q[i] !== 2'(i) || s_wr_data_q[i] !== exp_word) begin
                    errors++;
                    $display("[TB] FAIL ovf_word%0d: got %0d:%h required %0d:%h", i, s_wr_addr_q[i], s_wr_data_q[i], i, exp_word);
                end
            end
        end
        checks++;
        if (s_overflow !== 1'b1 || s_data_done !== 1'b1 || overflow !== 1'b0) begin
            errors++;
            $display("[TB] FAIL ovf_flags: got small_ovf=%b small_done=%b wide_ovf=%b required 1 1 0", s_overflow, s_data_done, overflow);
        end
        checks++;
        if (wr_data_q.size() != 5 || tx_q.size() != 2) begin
            errors++;
            $display("[TB] FAIL ovf_wide: got writes=%0d tx=%0d required 5 2", wr_data_q.size(), tx_q.size());
        end
    endtask

    task automatic test_zero_size();
        clear_logs();
        do_start();
        checks++;
        if (s_overflow !== 1'b0 || data_done !== 1'b0) begin
            errors++;
            $display("[TB] FAIL zero_clear: got ovf=%b done=%b required 0 0", s_overflow, data_done);
        end
        next_cycle();
        send_size(32'd0);
        checks++;
        if (tx_valid !== 1'b1 || tx_data !== 8'hAA || size_done !== 1'b1) begin
            errors++;
            $display("[TB] FAIL zero_ack: got valid=%b data=%h size_flag=%b required 1 AA 1", tx_valid, tx_data, size_done);
        end
        wait_done("zero");
        checks++;
        if (wr_data_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL zero_writes: got %0d required 0", wr_data_q.size());
        end
    endtask

    task automatic test_reset_midload();
        clear_logs();
        do_start();
        next_cycle();
        send_size(32'd8);
        send_byte(8'h01); send_byte(8'h02); send_byte(8'h03);
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if ({tx_valid, tx_data, prog_we, prog_addr, prog_wdata, prog_size,
             size_done, data_done, overflow, busy} !== '0) begin
            errors++;
            $display("[TB] FAIL midload_reset: tx_valid=%b tx_data=%h we=%b addr=%h wdata=%h size=%h flags=%b%b ovf=%b busy=%b required all 0",
                     tx_valid, tx_data, prog_we, prog_addr, prog_wdata, prog_size, size_done, data_done, overflow, busy);
        end
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        next_cycle();
        clear_logs();
        do_start();
        next_cycle();
        send_size(32'd4);
        send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
        wait_done("reload");
        checks++;
        if (wr_data_q.size() != 1 || wr_addr_q[0] !== 15'd0 || wr_data_q[0] !== 32'h04030201) begin
            errors++;
            $display("[TB] FAIL reload_write: got %0d writes first=%h required 1 at addr 0 = 04030201",
                     wr_data_q.size(), (wr_data_q.size() > 0) ? wr_data_q[0] : 32'h0);
        end
    endtask

    initial begin
        test_reset();
        test_basic_load();
        test_partial_word();
        test_backpressure();
        test_overflow();
        test_zero_size();
        test_reset_midload();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/program_loader.md
# program_loader

Boot-time program loader sitting directly upstream of the CPU state controller. On `start` it sends the 0x99 request byte over UART, receives a 4-byte program size and then that many program bytes, packs them into 32-bit words, and writes them to program memory. It then sends the 0xAA acknowledge byte and raises the two fetch-finished flags the state controller waits on before running the core.

## Interface
- `ADDR_WIDTH`, default 15: program-memory word-address width; capacity is `4 * 2**ADDR_WIDTH` bytes.
- `clk`  in  1: single clock for the whole block.
- `reset_n`  in  1: asynchronous active-low reset.
- `start`  in  1: one-cycle pulse that begins a load. Ignored unless state is IDLE or DONE.
- `rx_valid`  in  1: one-cycle strobe from the UART receiver; a byte is present on `rx_data`.
- `rx_data`  in  8: received byte.
- `tx_ready`  in  1: UART transmitter can accept a byte.
- `tx_valid`  out  1: byte on `tx_data` offered to the transmitter.
- `tx_data`  out  8: byte to transmit (0x99 or 0xAA).
- `prog_we`  out  1: program-memory write strobe, one cycle per word.
- `prog_addr`  out  ADDR_WIDTH: program-memory word address.
- `prog_wdata`  out  32: program-memory write data.
- `program_data_size`  out  32: received size in bytes.
- `program_data_size_fetch_finished`  out  1: size field complete (level).
- `program_data_fetch_finished`  out  1: all data written and 0xAA sent (level).
- `overflow`  out  1: size exceeded capacity; excess bytes were dropped.
- `busy`  out  1: state is neither IDLE nor DONE.

## Operation
- **States:** IDLE, SEND_99, RECV_SIZE, RECV_DATA, FLUSH, SEND_AA, DONE.
- **IDLE/DONE + `start`:** go to SEND_99. Clear the byte counter, byte lane, word address, size, both finished flags and `overflow`.
- **SEND_99:** `tx_valid=1`, `tx_data=0x99`. On the cycle `tx_valid && tx_ready`, go to RECV_SIZE.
- **RECV_SIZE:** accept 4 bytes, little-endian (first byte is bits [7:0]).
  - On the 4th byte, load `program_data_size` and set `program_data_size_fetch_finished`.
  - If size == 0, go to SEND_AA; otherwise go to RECV_DATA.
- **RECV_DATA:** each byte fills lane 0..3 of the word assembler, little-endian.
  - When lane 3 is filled, or the final byte (byte counter == size−1) arrives, the word is written. Unfilled lanes are 0.
  - After the final byte, go to FLUSH.
- **FLUSH:** one cycle that completes the last write, then go to SEND_AA.
- **SEND_AA:** handshake identical to SEND_99 with `tx_data=0xAA`. On handshake, set `program_data_fetch_finished` and go to DONE.
- **Capacity:** bytes whose word address would be ≥ `2**ADDR_WIDTH` are counted but not written, and `overflow` is set (sticky until the next `start`).
- **Byte counter:** 32-bit; the compare uses the full 32 bits.
- **Ignored input:** `rx_valid` outside RECV_SIZE and RECV_DATA is ignored. `start` while busy is ignored.
- **Reset mid-load:** all state is lost and the block returns to IDLE. Partially written memory is not cleaned.

## Timing
- **Reset values:** state IDLE; `tx_valid=0`, `tx_data=0x00`, `prog_we=0`, `prog_addr=0`, `prog_wdata=0`, `program_data_size=0`, both finished flags 0, `overflow=0`, `busy=0`.
- **Output registration:** all outputs are registered except `tx_valid`, `tx_data` and `busy`, which decode the state.
- **`start` to `tx_valid`:** `tx_valid` rises the cycle after `start`.
- **TX hold:** `tx_valid` and `tx_data` stay stable until `tx_ready`. `tx_valid` drops the cycle after the handshake.
- **Size flag:** `program_data_size_fetch_finished` rises 1 cycle after the 4th size byte strobe. It stays high until the next `start`.
- **Write latency:** `prog_we` pulses exactly 1 cycle, the cycle after the completing byte strobe.
  - `prog_addr` and `prog_wdata` are valid in that same cycle.
  - `prog_addr` increments after each write; the first write is to address 0.
- **Back-to-back bytes:** `rx_valid` on consecutive cycles is accepted at full rate; no byte is dropped.
- **Done flag:** `program_data_fetch_finished` rises 1 cycle after the 0xAA handshake. It stays high until the next `start` or reset.

## Test plan
- **Basic load:** `start`, `tx_ready=1`; send size 08 00 00 00, then 13 00 00 00 93 00 10 00 -> `tx_data` 0x99 then 0xAA; writes addr0=0x00000013, addr1=0x00100093; `program_data_size`=8; both flags high.
- **Partial word:** size 5, data 11 22 33 44 55 -> addr0=0x44332211, addr1=0x00000055; exactly 2 `prog_we` pulses.
- **Zero size:** size 0 -> no `prog_we`; 0xAA sent immediately after the size; `program_data_fetch_finished`=1.
- **TX backpressure:** hold `tx_ready=0` for 10 cycles in SEND_99 -> `tx_valid` held with 0x99 throughout; size bytes sent during the stall are ignored.
- **Overflow:** `ADDR_WIDTH`=2, size 20 -> writes to addr 0..3 only; `overflow`=1; 0xAA still sent.
- **Reset mid-load:** assert `reset_n` low after 3 data bytes -> all outputs return to reset values asynchronously; a new `start` reloads correctly from addr 0.
